// File: rtl/triangle_classifier_if.sv
// Side-length input stream and cosine/class output stream of the triangle classifier.
interface triangle_classifier_if;
  logic        in_valid;
  logic [7:0]  in_length;
  logic        out_valid;
  logic [15:0] out_cos;
  logic [1:0]  out_tri;

  // Stimulus side: drives side lengths, observes results.
  modport master (
    output in_valid, in_length,
    input  out_valid, out_cos, out_tri
  );

  // Classifier side: consumes side lengths, produces results.
  modport slave (
    input  in_valid, in_length,
    output out_valid, out_cos, out_tri
  );
endinterface

// File: rtl/triangle_classifier.sv
// Triangle classifier: latches sides a, b, c on three consecutive cycles,
// computes cos(A), cos(B), cos(C) in Q2.14 with one shared restoring divider,
// classifies the triangle and streams the three cosines out on three cycles.
module triangle_classifier (
  input  logic                  clk,
  input  logic                  rst_n,   // synchronous, active-high despite the name
  triangle_classifier_if.slave  tri_if
);

  typedef enum logic [2:0] {S_IDLE, S_IN1, S_IN2, S_CALC, S_OUT} state_t;
  typedef enum logic [1:0] {TRI_ACUTE = 2'd0, TRI_RIGHT = 2'd1, TRI_OBTUSE = 2'd2} tri_class_t;

  // |cos| < 1 means the quotient has 14 magnitude bits; one bit per step.
  localparam logic [3:0] LAST_STEP = 4'd14;

  state_t      r_state, w_state_next;
  logic [7:0]  r_a, r_b, r_c;
  logic [1:0]  r_angle;      // 0 = A, 1 = B, 2 = C
  logic [3:0]  r_iter;       // 0 = load divider, 1..14 = quotient steps
  logic [16:0] r_rem;
  logic [12:0] r_quot;
  logic        r_neg;
  logic [15:0] r_cos_a, r_cos_b, r_cos_c;
  logic [1:0]  r_out_idx;
  logic        r_out_valid;
  logic [15:0] r_out_cos;
  logic [1:0]  r_out_tri;

  logic [15:0] w_sq_a, w_sq_b, w_sq_c;
  logic [15:0] w_sq_opp, w_sq_s1, w_sq_s2;
  logic [7:0]  w_s1, w_s2;
  logic [15:0] w_prod;
  logic [16:0] w_den;
  logic signed [18:0] w_num;
  logic [16:0] w_num_mag;
  logic [17:0] w_rem_sh;
  logic        w_ge;
  logic [16:0] w_rem_next;
  logic [13:0] w_quot_next;
  logic [15:0] w_cos;
  logic [15:0] w_l_sq;
  logic [16:0] w_others_sq;
  tri_class_t  w_class;
  logic        w_calc_done;

  assign w_sq_a = {8'd0, r_a} * {8'd0, r_a};
  assign w_sq_b = {8'd0, r_b} * {8'd0, r_b};
  assign w_sq_c = {8'd0, r_c} * {8'd0, r_c};

  // Rotate the sides so the angle being computed is always opposite w_sq_opp.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_sq_opp = w_sq_a;
    w_sq_s1  = w_sq_b;
    w_sq_s2  = w_sq_c;
    w_s1     = r_b;
    w_s2     = r_c;
    case (r_angle)
      2'd1: begin
        w_sq_opp = w_sq_b; w_sq_s1 = w_sq_c; w_sq_s2 = w_sq_a;
        w_s1     = r_c;    w_s2    = r_a;
      end
      2'd2: begin
        w_sq_opp = w_sq_c; w_sq_s1 = w_sq_a; w_sq_s2 = w_sq_b;
        w_s1     = r_a;    w_s2    = r_b;
      end
      default: ;
    endcase
  end

  assign w_prod    = {8'd0, w_s1} * {8'd0, w_s2};
  assign w_den     = {w_prod, 1'b0};
  assign w_num     = $signed({3'b000, w_sq_s1}) + $signed({3'b000, w_sq_s2})
                   - $signed({3'b000, w_sq_opp});
  // Divide magnitudes so truncation is toward zero; sign is reapplied at the end.
  assign w_num_mag = w_num[18] ? 17'(-w_num) : 17'(w_num);

  // One restoring-division step. The remainder starts at |num| (< den), and
  // the 14 low dividend bits of |num| * 2^14 are all zero.
  assign w_rem_sh    = {r_rem, 1'b0};
  assign w_ge        = (w_rem_sh >= {1'b0, w_den});
  assign w_rem_next  = w_ge ? 17'(w_rem_sh - {1'b0, w_den}) : w_rem_sh[16:0];
  assign w_quot_next = {r_quot, w_ge};
  assign w_cos       = r_neg ? 16'(-{2'b00, w_quot_next}) : {2'b00, w_quot_next};

  // Classify on exact integer squares against the largest side.
  always_comb begin
    w_l_sq      = w_sq_c;
    w_others_sq = {1'b0, w_sq_a} + {1'b0, w_sq_b};
    if (r_a >= r_b && r_a >= r_c) begin
      w_l_sq      = w_sq_a;
      w_others_sq = {1'b0, w_sq_b} + {1'b0, w_sq_c};
    end else if (r_b >= r_c) begin
      w_l_sq      = w_sq_b;
      w_others_sq = {1'b0, w_sq_a} + {1'b0, w_sq_c};
    end
    if (w_others_sq == {1'b0, w_l_sq})
      w_class = TRI_RIGHT;
    else if (w_others_sq < {1'b0, w_l_sq})
      w_class = TRI_OBTUSE;
    else
      w_class = TRI_ACUTE;
  end

  assign w_calc_done = (r_state == S_CALC) && (r_iter == LAST_STEP) && (r_angle == 2'd2);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (tri_if.in_valid) w_state_next = S_IN1;
      S_IN1:   w_state_next = S_IN2;
      S_IN2:   w_state_next = S_CALC;
      S_CALC:  if (w_calc_done) w_state_next = S_OUT;
      S_OUT:   if (r_out_idx == 2'd2) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Side capture and divider datapath.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; each triangle reloads them before they are read.
    case (r_state)
      S_IDLE: if (tri_if.in_valid) r_a <= tri_if.in_length;
      S_IN1:  r_b <= tri_if.in_length;
      S_IN2:  r_c <= tri_if.in_length;
      S_CALC: begin
        if (r_iter == 4'd0) begin
          r_rem  <= w_num_mag;
          r_quot <= '0;
          r_neg  <= w_num[18];
        end else begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next[12:0];
          if (r_iter == LAST_STEP) begin
            case (r_angle)
              2'd0:    r_cos_a <= w_cos;
              2'd1:    r_cos_b <= w_cos;
              default: r_cos_c <= w_cos;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // Angle/step sequencing and registered output stream.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_angle     <= 2'd0;
      r_iter      <= 4'd0;
      r_out_idx   <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_cos   <= 16'd0;
      r_out_tri   <= 2'd0;
    end else begin
      case (r_state)
        S_IN2: begin
          r_angle <= 2'd0;
          r_iter  <= 4'd0;
        end
        S_CALC: begin
          if (r_iter == LAST_STEP) begin
            r_iter <= 4'd0;
            if (r_angle != 2'd2) begin
              r_angle <= r_angle + 2'd1;
            end else begin
              r_out_valid <= 1'b1;
              r_out_cos   <= r_cos_a;
              r_out_tri   <= w_class;
              r_out_idx   <= 2'd0;
            end
          end else begin
            r_iter <= r_iter + 4'd1;
          end
        end
        S_OUT: begin
          if (r_out_idx == 2'd2) begin
            r_out_valid <= 1'b0;
            r_out_cos   <= 16'd0;
            r_out_tri   <= 2'd0;
          end else begin
            r_out_idx <= r_out_idx + 2'd1;
            r_out_cos <= (r_out_idx == 2'd0) ? r_cos_b : r_cos_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign tri_if.out_valid = r_out_valid;
  assign tri_if.out_cos   = r_out_cos;
  assign tri_if.out_tri   = r_out_tri;

endmodule

// File: tb/tb_triangle_classifier.sv
// Self-checking bench for triangle_classifier: directed cases with known
// cosines, a mid-output reset, back-to-back extremes and random triangles
// checked against an integer-arithmetic reference model.
module tb_triangle_classifier;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  triangle_classifier_if tri_if ();

  triangle_classifier TRIANGLE (
    .clk    (clk),
    .rst_n  (rst_n),
    .tri_if (tri_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // cos of the angle opposite 'opp', truncated toward zero, Q2.14.
  function automatic logic [15:0] ref_cos(input int opp, input int s1, input int s2);
    longint num, den, q;
    num = longint'(s1 * s1 + s2 * s2 - opp * opp);
    den = longint'(2 * s1 * s2);
    q   = (num * 16384) / den;
    return q[15:0];
  endfunction

  function automatic logic [1:0] ref_tri(input int a, input int b, input int c);
    int l, x, y;
    if (a >= b && a >= c) begin l = a; x = b; y = c; end
    else if (b >= c)      begin l = b; x = a; y = c; end
    else                  begin l = c; x = a; y = b; end
    if (x * x + y * y == l * l) return 2'd1;
    if (x * x + y * y <  l * l) return 2'd2;
    return 2'd0;
  endfunction

  task automatic drive_sides(input int a, input int b, input int c);
    @(posedge clk); #1; tri_if.in_valid = 1'b1; tri_if.in_length = 8'(a);
    @(posedge clk); #1; tri_if.in_length = 8'(b);
    @(posedge clk); #1; tri_if.in_length = 8'(c);
    @(posedge clk); #1; tri_if.in_valid = 1'b0; tri_if.in_length = 8'($urandom);
  endtask

  // Counts cycles from the last in_valid cycle to the first out_valid cycle.
  task automatic wait_out(input string tag);
    int lat = 0;
    while (tri_if.out_valid !== 1'b1 && lat < 150) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency_in_1_100"}, 32'(lat >= 1 && lat <= 100), 32'd1);
  endtask

  task automatic run_triangle(input int a, input int b, input int c,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic [15:0] ec, input logic [1:0] et,
                              input string tag);
    logic [15:0] exp_cos [3];
    exp_cos = '{ea, eb, ec};
    drive_sides(a, b, c);
    wait_out(tag);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s valid%0d", tag, k), 32'(tri_if.out_valid), 32'd1);
      check($sformatf("%s cos%0d", tag, k), 32'(tri_if.out_cos), 32'(exp_cos[k]));
      check($sformatf("%s tri%0d", tag, k), 32'(tri_if.out_tri), 32'(et));
    end
    @(negedge clk);
    check({tag, " valid_after"}, 32'(tri_if.out_valid), 32'd0);
    check({tag, " cos_after"}, 32'(tri_if.out_cos), 32'd0);
    check({tag, " tri_after"}, 32'(tri_if.out_tri), 32'd0);
  endtask

  task automatic run_model(input int a, input int b, input int c, input string tag);
    run_triangle(a, b, c, ref_cos(a, b, c), ref_cos(b, c, a), ref_cos(c, a, b),
                 ref_tri(a, b, c), tag);
  endtask

  initial begin
    int stray;
    rst_n            = 1'b1;
    tri_if.in_valid  = 1'b0;
    tri_if.in_length = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset out_valid", 32'(tri_if.out_valid), 32'd0);
    check("reset out_cos", 32'(tri_if.out_cos), 32'd0);
    check("reset out_tri", 32'(tri_if.out_tri), 32'd0);

    // Directed cases with hand-derived results.
    run_triangle(3, 4, 5, 16'h3333, 16'h2666, 16'h0000, 2'd1, "right_345");
    run_triangle(5, 5, 5, 16'h2000, 16'h2000, 16'h2000, 2'd0, "equi_555");
    run_triangle(2, 2, 3, 16'h3000, 16'h3000, 16'hF800, 2'd2, "obtuse_223");
    run_triangle(3, 4, 6, 16'h3955, 16'h338E, 16'hE2AB, 2'd2, "trunc_346");
    run_triangle(255, 255, 255, 16'h2000, 16'h2000, 16'h2000, 2'd0, "max_255");
    run_triangle(1, 1, 1, 16'h2000, 16'h2000, 16'h2000, 2'd0, "min_111");

    // Reset during the first output cycle aborts the triangle.
    drive_sides(3, 4, 5);
    wait_out("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid valid_edge1", 32'(tri_if.out_valid), 32'd0);
    check("rst_mid cos_edge1", 32'(tri_if.out_cos), 32'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid valid_release", 32'(tri_if.out_valid), 32'd0);
    check("rst_mid cos_release", 32'(tri_if.out_cos), 32'd0);
    check("rst_mid tri_release", 32'(tri_if.out_tri), 32'd0);
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tri_if.out_valid === 1'b1) stray++;
    end
    check("rst_mid no_partial_output", 32'(stray), 32'd0);

    run_model(5, 12, 13, "right_51213");
    run_model(7, 8, 9, "after_reset_789");

    for (int t = 0; t < 20; t++) begin
      int a, b, c, lo, hi;
      a  = int'($urandom_range(255, 1));
      b  = int'($urandom_range(255, 1));
      lo = (a > b) ? a - b + 1 : b - a + 1;
      hi = (a + b - 1 > 255) ? 255 : a + b - 1;
      c  = int'($urandom_range(hi, lo));
      run_model(a, b, c, $sformatf("rand%0d_%0d_%0d_%0d", t, a, b, c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/triangle_classifier.md
# triangle_classifier

Sequential block that accepts three triangle side lengths over three consecutive cycles. It computes the cosine of each interior angle in signed fixed point and classifies the triangle as acute, right or obtuse. Results are streamed out over three consecutive cycles. It is the DUT of the triangle online-test bench; the module is instantiated as `TRIANGLE`.

## Interface
Parameters: none.

- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  reset, synchronous and active-high (asserted = 1) despite the name
- in_valid  input  1  high for exactly 3 consecutive cycles per triangle
- in_length  input  8  side length, unsigned, 1..255; side a, then b, then c
- out_valid  output  1  high for exactly 3 consecutive cycles per triangle
- out_cos  output  16  cosine, two's complement Q2.14 (value = out_cos / 16384)
- out_tri  output  2  class code: 0 = acute, 1 = right, 2 = obtuse; 3 is never produced

## Operation
- Reset behaviour:
  - While rst_n = 1 at a clock edge, all state returns to IDLE.
  - out_valid, out_cos and out_tri are 0 from that edge on.
  - Reset mid-input or mid-output aborts the triangle; no partial output follows.
- Input contract:
  - The stimulus always forms a valid non-degenerate triangle: each side is strictly less than the sum of the other two.
  - The DUT need not check this.
- FSM:
  - IDLE → IN1 on the first in_valid cycle (latch a).
  - IN1 → IN2 (latch b).
  - IN2 → CALC (latch c).
  - CALC → OUT once all three cosines are ready.
  - OUT lasts exactly 3 cycles, then returns to IDLE.
- Cosine arithmetic:
  - cos(A) = (b²+c²−a²)/(2bc), where A is the angle opposite side a. cos(B) and cos(C) are cyclic.
  - Numerator is signed 19 bits; denominator is unsigned 17 bits (max 130050).
  - Compute q = (num · 2^14) / den as signed division, truncated toward zero. Needs a ≥33-bit signed dividend.
  - |cos| < 1 for any valid triangle, so q fits in 16 bits without saturation.
  - A sequential (restoring/non-restoring) divider shared across the three angles is acceptable.
- Classification:
  - Let L be the largest side and x, y the other two.
  - Right (1) if x²+y² = L², compared exactly on integer squares.
  - Obtuse (2) if x²+y² < L².
  - Otherwise acute (0).
- Output order: cycle 1 = cos(A), cycle 2 = cos(B), cycle 3 = cos(C).
- out_tri holds the class value during all 3 out_valid cycles.
- out_cos and out_tri are 0 whenever out_valid = 0.

## Timing
- Outputs are registered.
- Input capture: in_valid/in_length are sampled on 3 consecutive edges. in_length is don't-care when in_valid = 0.
- Latency: the first out_valid cycle occurs 1 to 100 cycles after the last in_valid cycle.
- out_valid never overlaps in_valid.
- out_valid is exactly 3 consecutive cycles; never 2 or 4, and never split.
- The next triangle's in_valid may start 1 cycle after out_valid falls.
- Inputs arriving while not IDLE cannot occur and need no handling.
- Back-to-back triangles must not carry over state; all intermediates are reloaded per triangle.

## Test plan
- Reset: hold rst_n = 1 for 2 cycles mid-output, then release → out_valid/out_cos/out_tri = 0 the cycle after the edge; next triangle is processed normally.
- Right 3,4,5 → out_tri = 1; out_cos = 0x3333 (13107), 0x2666 (9830), 0x0000.
- Acute equilateral 5,5,5 → out_tri = 0; out_cos = 0x2000 on all three cycles.
- Obtuse 2,2,3 → out_tri = 2; out_cos = 0x3000, 0x3000, 0xF800 (−2048).
- Truncation toward zero, 3,4,6 (obtuse) → out_cos[C] = 0xE2AB (−7509, not −7510).
- Extremes: 255,255,255 → 0x2000 ×3, acute. Then 1,1,1 back-to-back → 0x2000 ×3. Check both latencies are ≤100 and out_valid is exactly 3 cycles each.
